crossfade_ramp: RTL and testbench

- Control-side driver for the crossfader `level` input: turns an abrupt level request (bypass footswitch, preset recall, pot jump) into a click-free, sample-paced ramp on an 8-bit level bus.
- Sits between the control/UI logic and the crossfader instance in the effect chain.
- Runs on the system clock and advances only on audio sample strobes.

---
 rtl/crossfade_pkg.sv | 31 +++
 rtl/crossfade_ramp_sample_divider.sv | 37 +++
 rtl/crossfade_ramp.sv | 103 ++++++++++
 tb/tb_crossfade_ramp.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/crossfade_pkg.sv
// Shared types and saturating step helpers for the crossfade level ramp.
package crossfade_pkg;

  localparam int unsigned LEVEL_W = 8;
  localparam logic [LEVEL_W-1:0] LEVEL_MIN = 8'd0;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StUp   = 2'd1;
  localparam state_t StDown = 2'd2;

  // Step toward a higher target, clamping at the target (9-bit sum cannot wrap).
  function automatic logic [LEVEL_W-1:0] step_up(input logic [LEVEL_W-1:0] lvl,
                                                 input logic [LEVEL_W-1:0] tgt,
                                                 input logic [LEVEL_W-1:0] step);
    logic [LEVEL_W:0] sum;
    sum = {1'b0, lvl} + {1'b0, step};
    return (sum >= {1'b0, tgt}) ? tgt : sum[LEVEL_W-1:0];
  endfunction

  // Step toward a lower target; a borrow out means we passed zero, so clamp.
  function automatic logic [LEVEL_W-1:0] step_down(input logic [LEVEL_W-1:0] lvl,
                                                   input logic [LEVEL_W-1:0] tgt,
                                                   input logic [LEVEL_W-1:0] step);
    logic [LEVEL_W:0] diff;
    diff = {1'b0, lvl} - {1'b0, step};
    return (diff[LEVEL_W] || (diff[LEVEL_W-1:0] <= tgt)) ? tgt : diff[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/crossfade_ramp_sample_divider.sv
// Divides a sample strobe by (rate_i + 1), emitting a one-cycle step enable.
module sample_divider #(
  parameter int unsigned RateW = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             clear_i,
  input  logic [RateW-1:0] rate_i,
  output logic             step_o
);

  logic [RateW-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap   = (cnt_q == rate_i);
  // Clear has priority so a restart never produces a stale step.
  assign step_o = tick_i & ~clear_i & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/crossfade_ramp.sv
// Turns abrupt crossfader level requests into a sample-paced saturating ramp.
module crossfade_ramp
  import crossfade_pkg::*;
#(
  parameter int unsigned STEP        = 1,
  parameter int unsigned RATE_W      = 4,
  parameter int unsigned RESET_LEVEL = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sample_tick_i,
  input  logic [LEVEL_W-1:0] target_i,
  input  logic               target_valid_i,
  input  logic [RATE_W-1:0]  rate_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [LEVEL_W-1:0] StepC     = LEVEL_W'(STEP);
  localparam logic [LEVEL_W-1:0] ResetLvlC = LEVEL_W'(RESET_LEVEL);

  state_t              state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [LEVEL_W-1:0]  target_q, target_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                div_clear;
  logic                div_tick;
  logic                step_en;

  // Ticks are only counted while a ramp is active.
  assign div_tick = sample_tick_i & (state_q != StIdle);

  sample_divider #(
    .RateW (RATE_W)
  ) u_div (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .tick_i  (div_tick),
    .clear_i (div_clear),
    .rate_i  (rate_q),
    .step_o  (step_en)
  );

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    target_d  = target_q;
    rate_d    = rate_q;
    done_d    = 1'b0;
    div_clear = 1'b0;
    if (target_valid_i) begin
      // A new request always wins over a coincident step.
      target_d  = target_i;
      rate_d    = rate_i;
      div_clear = 1'b1;
      if (target_i > level_q) begin
        state_d = StUp;
      end else if (target_i < level_q) begin
        state_d = StDown;
      end else begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end else if (step_en) begin
      case (state_q)
        StUp:    level_d = step_up(level_q, target_q, StepC);
        StDown:  level_d = step_down(level_q, target_q, StepC);
        default: level_d = level_q;
      endcase
      if (level_d == target_q) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      level_q  <= ResetLvlC;
      target_q <= ResetLvlC;
      rate_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      rate_q   <= rate_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign level_o = level_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_crossfade_ramp.sv
// Scoreboard bench for crossfade_ramp: three instances cover STEP=1, 3 and 200.
module tb_crossfade_ramp;

  typedef struct packed {
    logic [7:0] lvl;
    logic       done;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       sample_tick_i;
  logic [7:0] target_i;
  logic       target_valid_i;
  logic [3:0] rate_i;

  logic [7:0] lvl0, lvl1, lvl2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  int   checks = 0;
  int   errors = 0;
  int   active = 0;
  bit   ending = 0;
  bit   ended  = 0;
  exp_t exp_q[$];

  crossfade_ramp #(.STEP(1), .RATE_W(4), .RESET_LEVEL(0)) dut0 (
    .clk_i (clk), .rst_i (rst_i), .sample_tick_i (sample_tick_i), .target_i (target_i),
    .target_valid_i (target_valid_i), .rate_i (rate_i), .level_o (lvl0), .busy_o (busy0),
    .done_o (done0)
  );
  crossfade_ramp #(.STEP(3), .RATE_W(4), .RESET_LEVEL(0)) dut1 (
    .clk_i (clk), .rst_i (rst_i), .sample_tick_i (sample_tick_i), .target_i (target_i),
    .target_valid_i (target_valid_i), .rate_i (rate_i), .level_o (lvl1), .busy_o (busy1),
    .done_o (done1)
  );
  crossfade_ramp #(.STEP(200), .RATE_W(4), .RESET_LEVEL(255)) dut2 (
    .clk_i (clk), .rst_i (rst_i), .sample_tick_i (sample_tick_i), .target_i (target_i),
    .target_valid_i (target_valid_i), .rate_i (rate_i), .level_o (lvl2), .busy_o (busy2),
    .done_o (done2)
  );

  always #5 clk = ~clk;

  logic [7:0] cur_lvl;
  logic       cur_busy, cur_done;
  always_comb begin
    cur_lvl  = lvl0;
    cur_busy = busy0;
    cur_done = done0;
    if (active == 1) begin
      cur_lvl = lvl1; cur_busy = busy1; cur_done = done1;
    end else if (active == 2) begin
      cur_lvl = lvl2; cur_busy = busy2; cur_done = done2;
    end
  end

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the only process that touches checks/errors.
  initial begin : monitor
    logic [7:0] prev;
    bit         rst_seen;
    exp_t       e;
    prev     = '0;
    rst_seen = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        if (!rst_seen) begin
          chk("rst_lvl0", {1'b0, lvl0}, 9'd0);
          chk("rst_busy0", {8'd0, busy0}, 9'd0);
          chk("rst_done0", {8'd0, done0}, 9'd0);
          chk("rst_lvl1", {1'b0, lvl1}, 9'd0);
          chk("rst_busy1", {8'd0, busy1}, 9'd0);
          chk("rst_lvl2", {1'b0, lvl2}, 9'd255);
          chk("rst_busy2", {8'd0, busy2}, 9'd0);
          rst_seen = 1;
        end
        prev = cur_lvl;
      end else begin
        rst_seen = 0;
        if (cur_lvl !== prev || cur_done === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got level %0d done %0b busy %0b expected no event at %0t",
                     cur_lvl, cur_done, cur_busy, $time);
          end else begin
            e = exp_q.pop_front();
            chk("event_level", {1'b0, cur_lvl}, {1'b0, e.lvl});
            chk("event_done", {8'd0, cur_done}, {8'd0, e.done});
            chk("event_busy", {8'd0, cur_busy}, {8'd0, e.busy});
          end
          prev = cur_lvl;
        end
        if (ending && !ended) begin
          chk("queue_empty", 9'(exp_q.size()), 9'd0);
          ended = 1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int a);
    @(posedge clk);
    #2 rst_i = 1'b1;
    active = a;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    cyc(1);
  endtask

  task automatic tick(input int gap);
    sample_tick_i = 1'b1;
    cyc(1);
    sample_tick_i = 1'b0;
    cyc(gap);
  endtask

  task automatic accept(input logic [7:0] t, input logic [3:0] r, input logic with_tick);
    target_i       = t;
    rate_i         = r;
    target_valid_i = 1'b1;
    sample_tick_i  = with_tick;
    cyc(1);
    target_valid_i = 1'b0;
    sample_tick_i  = 1'b0;
    rate_i         = 4'hf;
    cyc(1);
  endtask

  task automatic push(input logic [7:0] l, input logic d, input logic b);
    exp_q.push_back('{lvl: l, done: d, busy: b});
  endtask

  initial begin
    rst_i = 1'b0; sample_tick_i = 1'b0; target_i = '0; target_valid_i = 1'b0; rate_i = '0;

    // Up ramp 0 -> 4, STEP=1, rate 0, ticks every 10 clocks.
    do_reset(0);
    push(8'd1, 1'b0, 1'b1); push(8'd2, 1'b0, 1'b1); push(8'd3, 1'b0, 1'b1);
    push(8'd4, 1'b1, 1'b0);
    accept(8'd4, 4'd0, 1'b0);
    repeat (6) tick(9);

    // Saturating STEP=3, rate 1: 3, 6, then clamp at 7.
    do_reset(1);
    push(8'd3, 1'b0, 1'b1); push(8'd6, 1'b0, 1'b1); push(8'd7, 1'b1, 1'b0);
    accept(8'd7, 4'd1, 1'b0);
    repeat (8) tick(3);

    // STEP=200 down from 255: 55, then clamp at 0 without wrapping.
    do_reset(2);
    push(8'd55, 1'b0, 1'b1); push(8'd0, 1'b1, 1'b0);
    accept(8'd0, 4'd0, 1'b0);
    repeat (3) tick(2);

    // Retarget 0 -> 200 reversed at 100 toward 50.
    do_reset(0);
    for (int i = 1; i <= 100; i++) push(8'(i), 1'b0, 1'b1);
    accept(8'd200, 4'd0, 1'b0);
    repeat (100) tick(1);
    for (int i = 99; i >= 51; i--) push(8'(i), 1'b0, 1'b1);
    push(8'd50, 1'b1, 1'b0);
    accept(8'd50, 4'd0, 1'b0);
    repeat (52) tick(1);

    // Target equal to current level: done only.
    push(8'd50, 1'b1, 1'b0);
    accept(8'd50, 4'd0, 1'b0);
    cyc(3);

    // Accept coincident with a would-be stepping tick restarts the divider.
    accept(8'd60, 4'd1, 1'b0);
    tick(2);
    accept(8'd60, 4'd1, 1'b1);
    tick(2);
    push(8'd51, 1'b0, 1'b1);
    tick(2);
    push(8'd51, 1'b1, 1'b0);
    accept(8'd51, 4'd0, 1'b0);
    cyc(2);

    // Asynchronous reset mid-ramp: no done pulse, reset values immediately.
    push(8'd52, 1'b0, 1'b1);
    accept(8'd60, 4'd0, 1'b0);
    tick(1);
    do_reset(0);
    repeat (3) tick(2);

    ending = 1;
    cyc(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
